// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Fetches over a req/ready handshake, buffers one word under freeze, drains outstanding requests on branch.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [31:0] PC,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redirect_q, redirect_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcout_q, pcout_d;
    logic        valid_q, valid_d;

    logic        transfer;
    logic [31:0] pc_inc;

    // No request while held in reset or while a fetched word waits in the buffer.
    assign imem_req    = rst & (state_q != S_HOLD);
    assign imem_addr   = pc_q;
    assign transfer    = imem_req & imem_ready;
    assign pc_inc      = pc_q + 32'd4;

    assign Instruction = instr_q;
    assign PC          = pcout_q;
    assign if_valid    = valid_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redirect_d = redirect_q;
        buf_d      = buf_q;
        buf_pc_d   = buf_pc_q;
        instr_d    = instr_q;
        pcout_d    = pcout_q;
        valid_d    = valid_q;

        case (state_q)
            S_RUN: begin
                if (branch_taken) begin
                    instr_d = NOP_INSTR;
                    pcout_d = 32'd0;
                    valid_d = 1'b0;
                    if (transfer) begin
                        pc_d = branch_addr;
                    end else begin
                        // The request cannot be withdrawn; remember the target until it completes.
                        redirect_d = branch_addr;
                        state_d    = S_DRAIN;
                    end
                end else if (freeze) begin
                    if (transfer) begin
                        buf_d    = imem_rdata;
                        buf_pc_d = pc_inc;
                        pc_d     = pc_inc;
                        state_d  = S_HOLD;
                    end
                end else if (transfer) begin
                    instr_d = imem_rdata;
                    pcout_d = pc_inc;
                    valid_d = 1'b1;
                    pc_d    = pc_inc;
                end else begin
                    instr_d = NOP_INSTR;
                    pcout_d = 32'd0;
                    valid_d = 1'b0;
                end
            end

            S_HOLD: begin
                if (branch_taken) begin
                    pc_d    = branch_addr;
                    instr_d = NOP_INSTR;
                    pcout_d = 32'd0;
                    valid_d = 1'b0;
                    state_d = S_RUN;
                end else if (!freeze) begin
                    instr_d = buf_q;
                    pcout_d = buf_pc_q;
                    valid_d = 1'b1;
                    state_d = S_RUN;
                end
            end

            S_DRAIN: begin
                instr_d = NOP_INSTR;
                pcout_d = 32'd0;
                valid_d = 1'b0;
                if (branch_taken) begin
                    redirect_d = branch_addr;
                end
                if (transfer) begin
                    pc_d    = branch_taken ? branch_addr : redirect_q;
                    state_d = S_RUN;
                end
            end

            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            redirect_q <= 32'd0;
            buf_q      <= 32'd0;
            buf_pc_q   <= 32'd0;
            instr_q    <= NOP_INSTR;
            pcout_q    <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            buf_q      <= buf_d;
            buf_pc_q   <= buf_pc_d;
            instr_q    <= instr_d;
            pcout_q    <= pcout_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed test-plan sequences, then randomized traffic against a behavioural model.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic        if_valid;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic        w_valid;

    bit          mem_mode;
    int          n_checks;
    int          n_fail;

    function automatic logic [31:0] scramble(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = !imem_ready ? 32'hDEAD_BEEF : (mem_mode ? scramble(imem_addr) : imem_addr);

    fetch_stage u_dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .Instruction(Instruction),
        .PC(PC), .if_valid(if_valid)
    );

    // Second instance checks PC wrap-around from the top of the address space.
    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .freeze(1'b0), .branch_taken(1'b0),
        .branch_addr(32'd0), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ready(1'b1), .imem_rdata(w_addr), .Instruction(w_instr),
        .PC(w_pc), .if_valid(w_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a buffer queue of frozen words, a pending redirect, and the IF/ID contents.
    typedef struct {
        logic [31:0] w;
        logic [31:0] p;
    } ent_t;

    ent_t        q_buf[$];
    logic [31:0] m_pc;
    logic [31:0] m_target;
    logic [31:0] m_instr;
    logic [31:0] m_pcout;
    bit          m_valid;
    bit          m_draining;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void m_bubble();
        m_instr = 32'd0;
        m_pcout = 32'd0;
        m_valid = 1'b0;
    endfunction

    function automatic void model_reset();
        m_pc       = 32'd0;
        m_target   = 32'd0;
        m_draining = 1'b0;
        q_buf.delete();
        m_bubble();
    endfunction

    function automatic void model_edge(input bit rdy, input bit frz, input bit br, input logic [31:0] baddr);
        bit          xfer;
        logic [31:0] word;
        ent_t        e;
        xfer = (q_buf.size() == 0) && rdy;
        word = mem_mode ? scramble(m_pc) : m_pc;
        if (m_draining) begin
            m_bubble();
            if (br) m_target = baddr;
            if (xfer) begin
                m_pc       = m_target;
                m_draining = 1'b0;
            end
        end else if (q_buf.size() != 0) begin
            if (br) begin
                q_buf.delete();
                m_pc = baddr;
                m_bubble();
            end else if (!frz) begin
                e       = q_buf.pop_front();
                m_instr = e.w;
                m_pcout = e.p;
                m_valid = 1'b1;
            end
        end else if (br) begin
            m_bubble();
            if (xfer) m_pc = baddr;
            else begin
                m_target   = baddr;
                m_draining = 1'b1;
            end
        end else if (xfer) begin
            if (frz) begin
                e.w = word;
                e.p = m_pc + 32'd4;
                q_buf.push_back(e);
            end else begin
                m_instr = word;
                m_pcout = m_pc + 32'd4;
                m_valid = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end else if (!frz) begin
            m_bubble();
        end
    endfunction

    // Single compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        chk("imem_req", {31'd0, imem_req}, {31'd0, rst && (q_buf.size() == 0)});
        if (imem_req) chk("imem_addr", imem_addr, m_pc);
        chk("Instruction", Instruction, m_instr);
        chk("PC", PC, m_pcout);
        chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
    end

    task automatic step(input bit rdy, input bit frz, input bit br, input logic [31:0] baddr);
        imem_ready   = rdy;
        freeze       = frz;
        branch_taken = br;
        branch_addr  = baddr;
        @(posedge clk);
        if (rst) model_edge(rdy, frz, br, baddr);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        mem_mode     = 1'b0;
        rst          = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'd0;
        imem_ready   = 1'b0;
        model_reset();
        do_reset();

        // Zero-wait streaming from reset.
        chk("lit_first_addr", imem_addr, 32'h0);
        step(1, 0, 0, 0);
        chk("lit_i0", Instruction, 32'h0);
        chk("lit_pc0", PC, 32'h4);
        chk("lit_v0", {31'd0, if_valid}, 32'd1);
        chk("lit_wrap_pc", w_pc, 32'h0);
        chk("lit_wrap_instr", w_instr, 32'hFFFF_FFFC);
        chk("lit_wrap_addr", w_addr, 32'h0);
        step(1, 0, 0, 0);
        chk("lit_i1", Instruction, 32'h4);
        chk("lit_pc1", PC, 32'h8);
        step(1, 0, 0, 0);
        chk("lit_i2", Instruction, 32'h8);
        chk("lit_pc2", PC, 32'hC);

        // Branch during a transfer at 12.
        step(1, 0, 1, 32'h100);
        chk("lit_br_valid", {31'd0, if_valid}, 32'd0);
        chk("lit_br_addr", imem_addr, 32'h100);

        // Branch while request waits, then a second branch: latest target wins.
        step(0, 0, 1, 32'h200);
        chk("lit_dr_addr", imem_addr, 32'h100);
        step(0, 0, 1, 32'h300);
        step(0, 0, 0, 0);
        chk("lit_dr_valid", {31'd0, if_valid}, 32'd0);
        step(1, 0, 0, 0);
        chk("lit_dr_target", imem_addr, 32'h300);

        // Freeze with transfer, hold, release.
        step(1, 1, 0, 0);
        chk("lit_fz_req", {31'd0, imem_req}, 32'd0);
        step(1, 1, 0, 0);
        chk("lit_fz_valid", {31'd0, if_valid}, 32'd0);
        step(1, 0, 0, 0);
        chk("lit_fz_instr", Instruction, 32'h300);
        chk("lit_fz_pc", PC, 32'h304);
        chk("lit_fz_next", imem_addr, 32'h304);

        // One wait state.
        step(0, 0, 0, 0);
        chk("lit_ws_valid", {31'd0, if_valid}, 32'd0);
        step(1, 0, 0, 0);
        chk("lit_ws_instr", Instruction, 32'h304);
        chk("lit_ws_pc", PC, 32'h308);

        // Randomized traffic with occasional resets.
        mem_mode = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] ba;
            ba = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, ba);
            if (i % 997 == 500) do_reset();
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
